adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
Scheduler that decides when the ADC streaming ingest captures a frame. It drives the ingest's one-cycle `start` pulse and watches its `capture_busy`. Triggers come from the ADC's DRDY_n pin (synchronized, falling edge) or from an internal period timer. It adds burst-length control, missed-trigger accounting and a busy-handshake watchdog, and sits between the regbank control fields and the ingest block.

Parameters:
SYNC_STAGES, 2, flops in the adc_drdy_n synchronizer (min 2).
PERIOD_W, 24, width of the period_cycles input.
CNT_W, 16, width of burst_frames, frames_done and missed_triggers.
TIMEOUT_CYCLES, 4096, cycles allowed for each busy-handshake phase before a timeout is declared.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
enable  in  1  level; 1 = sequencer armed.
mode_periodic  in  1  trigger source: 0 = DRDY falling edge, 1 = internal timer.
period_cycles  in  PERIOD_W  timer period in clk cycles; values below 2 are treated as 2.
burst_frames  in  CNT_W  frames per burst; 0 = continuous.
adc_drdy_n  in  1  asynchronous ADC data-ready pin, active-low.
cap_start  out  1  one-cycle start pulse to the ingest.
cap_busy  in  1  capture_busy from the ingest.
seq_active  out  1  high in any state except IDLE.
burst_done  out  1  one-cycle pulse when a burst completes.
frames_done  out  CNT_W  completed frames; wraps modulo 2^CNT_W.
missed_triggers  out  CNT_W  triggers not serviced; saturates at all-ones.
timeout_sticky  out  1  a watchdog timeout occurred; sticky.
stat_clear  in  1  pulse; clears frames_done, missed_triggers and timeout_sticky.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE; all outputs 0.
  - Timer, watchdog and burst counter = 0.
  - Synchronizer flops = 1 (DRDY inactive).
- DRDY path:
  - adc_drdy_n passes through SYNC_STAGES flops, then one edge-detect flop.
  - A DRDY trigger is a 1→0 transition of the synchronized signal (single-cycle event).
  - Latency from pin fall to trigger is SYNC_STAGES+1 cycles.
  - The DRDY path is ignored when mode_periodic = 1.
- Timer path (mode_periodic = 1, state ≠ IDLE):
  - Down-counter loads max(period_cycles, 2) − 1 on IDLE→ARMED.
  - At 0 it fires a trigger and reloads the same value; it therefore fires every max(period_cycles, 2) cycles.
  - It keeps running in LAUNCH, CAPTURE and DONE so that overlapping ticks are counted as missed.
- Trigger handling:
  - In ARMED, a trigger registers cap_start = 1 on the next cycle (exactly one cycle high) and moves to LAUNCH.
  - A trigger in LAUNCH, CAPTURE or DONE increments missed_triggers (saturating). No queueing.
  - A trigger in IDLE is ignored and not counted.
- FSM:
  - IDLE: when enable = 1 → ARMED; burst counter := 0.
  - ARMED:
    - enable = 0 → IDLE.
    - Else trigger → LAUNCH, with the watchdog cleared.
  - LAUNCH (waiting for the ingest to accept):
    - cap_busy = 1 → CAPTURE, with the watchdog cleared.
    - If the watchdog reaches TIMEOUT_CYCLES: timeout_sticky := 1, then → ARMED if enable = 1, else IDLE.
  - CAPTURE:
    - On cap_busy = 0, frames_done increments and the burst counter increments.
    - If burst_frames ≠ 0 and the new burst count equals burst_frames: burst_done pulses (same cycle as the transition) and → DONE.
    - Otherwise → ARMED if enable = 1, else IDLE.
    - If the watchdog reaches TIMEOUT_CYCLES with cap_busy still 1: timeout_sticky := 1 and → IDLE. frames_done is not incremented.
  - DONE: holds until enable = 0, then → IDLE. A new burst requires enable to go low and then high again.
- Enable semantics:
  - Deasserting enable in LAUNCH or CAPTURE does not abort; the frame in flight completes first.
  - The ingest's `start` is ignored while it is busy; the sequencer never pulses cap_start outside ARMED.
- Statistics:
  - stat_clear zeroes all three statistics on the next edge.
  - If stat_clear coincides with an increment or a timeout, clear wins and the event is lost.
- Mid-operation changes:
  - Changing mode_periodic or period_cycles while not in IDLE is allowed. The new period takes effect at the next reload; a mode switch takes effect immediately.
  - Changing burst_frames mid-burst is compared against the live value. A live value of 0 makes the burst continuous.
  - Asserting rst_n low mid-capture returns to IDLE immediately; cap_start is forced to 0.

Test Plan:
1. DRDY mode, burst_frames=3, enable=1, drive three DRDY falls 200 cycles apart with a busy model (rise 1 cycle after start, 50 cycles long) → three cap_start pulses each SYNC_STAGES+2 cycles after the pin edge; frames_done=3; burst_done pulses once; state DONE; a 4th DRDY is counted as missed (1).
2. Periodic mode, period_cycles=100, burst_frames=0, busy 30 cycles → cap_start every 100 cycles; 0 missed after 10 frames. Change busy to 150 cycles → missed_triggers increments by 1 per frame.
3. cap_busy tied 0, TIMEOUT_CYCLES=16 → timeout_sticky=1 at cycle 16 after cap_start; state returns to ARMED; frames_done stays 0. Pulse stat_clear → timeout_sticky=0.
4. period_cycles=0 and period_cycles=1 → triggers every 2 cycles; missed_triggers saturates at 0xFFFF (CNT_W=16) with busy held long and never wraps.
5. Drop enable during CAPTURE → frame completes and frames_done increments; then IDLE with seq_active=0 and no further cap_start despite continued DRDY edges.
6. Assert rst_n low mid-LAUNCH with adc_drdy_n=0 → all outputs 0 asynchronously. After release, no spurious trigger until a fresh 1→0 DRDY edge.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// Capture scheduler for the ADC streaming ingest: turns DRDY falls or timer ticks
// into single start pulses, supervises the busy handshake and keeps frame statistics.
module adc_capture_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PERIOD_W       = 24,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode_periodic,
    input  logic [PERIOD_W-1:0] period_cycles,
    input  logic [CNT_W-1:0]    burst_frames,
    input  logic                adc_drdy_n,
    output logic                cap_start,
    input  logic                cap_busy,
    output logic                seq_active,
    output logic                burst_done,
    output logic [CNT_W-1:0]    frames_done,
    output logic [CNT_W-1:0]    missed_triggers,
    output logic                timeout_sticky,
    input  logic                stat_clear
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES:0]   warm_reg;
    logic                   drdy_prev_reg;
    logic                   drdy_trig_reg;
    logic [PERIOD_W-1:0]    timer_reg;
    logic [PERIOD_W-1:0]    reload_val;
    logic [WD_W-1:0]        wd_reg;
    logic [CNT_W-1:0]       burst_cnt_reg;
    logic [CNT_W-1:0]       burst_cnt_next;
    logic [CNT_W-1:0]       frames_reg;
    logic [CNT_W-1:0]       missed_reg;
    logic                   cap_start_reg;
    logic                   burst_done_reg;
    logic                   seq_active_reg;
    logic                   sticky_reg;

    logic timer_fire;
    logic trigger;
    logic wd_expired;
    logic frame_inc;
    logic missed_inc;
    logic timeout_evt;

    // The trigger is masked until every flop in the chain holds a real pin sample,
    // so a pin already low when reset releases does not read as a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg      <= '1;
            warm_reg      <= '0;
            drdy_prev_reg <= 1'b1;
            drdy_trig_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], adc_drdy_n};
            warm_reg      <= {warm_reg[SYNC_STAGES-1:0], 1'b1};
            drdy_prev_reg <= sync_reg[SYNC_STAGES-1];
            drdy_trig_reg <= warm_reg[SYNC_STAGES] & drdy_prev_reg & ~sync_reg[SYNC_STAGES-1];
        end
    end

    assign reload_val     = (period_cycles < PERIOD_W'(2)) ? PERIOD_W'(1) : period_cycles - 1'b1;
    assign timer_fire     = (state_reg != ST_IDLE) && (timer_reg == '0);
    assign trigger        = mode_periodic ? timer_fire : drdy_trig_reg;
    assign wd_expired     = (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign burst_cnt_next = burst_cnt_reg + 1'b1;
    assign frame_inc      = (state_reg == ST_CAPTURE) && !cap_busy;
    assign missed_inc     = trigger && (state_reg inside {ST_LAUNCH, ST_CAPTURE, ST_DONE});
    assign timeout_evt    = wd_expired &&
                            (((state_reg == ST_LAUNCH) && !cap_busy) ||
                             ((state_reg == ST_CAPTURE) && cap_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cap_start_reg  <= 1'b0;
            burst_done_reg <= 1'b0;
            seq_active_reg <= 1'b0;
            timer_reg      <= '0;
            wd_reg         <= '0;
            burst_cnt_reg  <= '0;
        end else begin
            cap_start_reg  <= 1'b0;
            burst_done_reg <= 1'b0;

            // The timer free-runs while active so ticks during a capture show up as missed.
            if (state_reg == ST_IDLE) begin
                if (enable) begin
                    timer_reg <= reload_val;
                end
            end else if (timer_fire) begin
                timer_reg <= reload_val;
            end else begin
                timer_reg <= timer_reg - 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_reg      <= ST_ARMED;
                        seq_active_reg <= 1'b1;
                        burst_cnt_reg  <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!enable) begin
                        state_reg      <= ST_IDLE;
                        seq_active_reg <= 1'b0;
                    end else if (trigger) begin
                        state_reg     <= ST_LAUNCH;
                        cap_start_reg <= 1'b1;
                        wd_reg        <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (cap_busy) begin
                        state_reg <= ST_CAPTURE;
                        wd_reg    <= '0;
                    end else if (wd_expired) begin
                        state_reg      <= enable ? ST_ARMED : ST_IDLE;
                        seq_active_reg <= enable;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (!cap_busy) begin
                        burst_cnt_reg <= burst_cnt_next;
                        if ((burst_frames != '0) && (burst_cnt_next == burst_frames)) begin
                            state_reg      <= ST_DONE;
                            burst_done_reg <= 1'b1;
                        end else begin
                            state_reg      <= enable ? ST_ARMED : ST_IDLE;
                            seq_active_reg <= enable;
                        end
                    end else if (wd_expired) begin
                        state_reg      <= ST_IDLE;
                        seq_active_reg <= 1'b0;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state_reg      <= ST_IDLE;
                        seq_active_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    seq_active_reg <= 1'b0;
                end
            endcase
        end
    end

    // A clear on the same edge as an event wins; the event is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_reg <= '0;
            missed_reg <= '0;
            sticky_reg <= 1'b0;
        end else if (stat_clear) begin
            frames_reg <= '0;
            missed_reg <= '0;
            sticky_reg <= 1'b0;
        end else begin
            if (frame_inc) begin
                frames_reg <= frames_reg + 1'b1;
            end
            if (missed_inc && (missed_reg != '1)) begin
                missed_reg <= missed_reg + 1'b1;
            end
            if (timeout_evt) begin
                sticky_reg <= 1'b1;
            end
        end
    end

    assign cap_start       = cap_start_reg;
    assign burst_done      = burst_done_reg;
    assign seq_active      = seq_active_reg;
    assign frames_done     = frames_reg;
    assign missed_triggers = missed_reg;
    assign timeout_sticky  = sticky_reg;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: directed scenarios plus random traffic, every cycle
// compared against a time-stamp based reference model of the scheduling rules.
module tb_adc_capture_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int PERIOD_W    = 12;
    localparam int CNT_W       = 8;
    localparam int TO          = 200;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                mode_periodic = 1'b0;
    logic [PERIOD_W-1:0] period_cycles = 100;
    logic [CNT_W-1:0]    burst_frames = '0;
    logic                adc_drdy_n = 1'b1;
    logic                cap_busy = 1'b0;
    logic                stat_clear = 1'b0;
    logic                cap_start;
    logic                seq_active;
    logic                burst_done;
    logic [CNT_W-1:0]    frames_done;
    logic [CNT_W-1:0]    missed_triggers;
    logic                timeout_sticky;

    adc_capture_sequencer #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PERIOD_W      (PERIOD_W),
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .mode_periodic  (mode_periodic),
        .period_cycles  (period_cycles),
        .burst_frames   (burst_frames),
        .adc_drdy_n     (adc_drdy_n),
        .cap_start      (cap_start),
        .cap_busy       (cap_busy),
        .seq_active     (seq_active),
        .burst_done     (burst_done),
        .frames_done    (frames_done),
        .missed_triggers(missed_triggers),
        .timeout_sticky (timeout_sticky),
        .stat_clear     (stat_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model. Phases: 0 off, 1 waiting for a trigger, 2 start issued and
    // waiting for busy, 3 busy, 4 burst complete. Timing uses absolute cycle stamps.
    int cyc = 0;
    int m_phase, m_old_phase, next_tick, deadline, burst_count;
    int e_frames, e_missed;
    bit e_sticky, e_start, e_bdone;
    bit m_drdy, m_tick, m_trig, frame_evt, miss_evt, to_evt;
    int pin_q[$];

    function automatic int eff_period(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic model_reset();
        m_phase = 0; burst_count = 0; next_tick = 0; deadline = 0;
        e_frames = 0; e_missed = 0; e_sticky = 0; e_start = 0; e_bdone = 0;
        pin_q.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) pin_q.push_back(2); // 2 = not yet sampled
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            m_drdy = (pin_q[0] == 1) && (pin_q[1] == 0);
            pin_q.push_back(int'(adc_drdy_n));
            void'(pin_q.pop_front());
            m_tick = 0;
            if (m_phase != 0 && cyc == next_tick) begin
                m_tick = 1;
                next_tick = cyc + eff_period(int'(period_cycles));
            end
            m_trig = mode_periodic ? m_tick : m_drdy;
            m_old_phase = m_phase;
            e_start = 0; e_bdone = 0; frame_evt = 0; to_evt = 0;
            miss_evt = m_trig && (m_old_phase >= 2);
            case (m_old_phase)
                0: if (enable) begin
                    m_phase = 1; burst_count = 0;
                    next_tick = cyc + eff_period(int'(period_cycles));
                end
                1: if (!enable) m_phase = 0;
                   else if (m_trig) begin m_phase = 2; e_start = 1; deadline = cyc + TO; end
                2: if (cap_busy) begin m_phase = 3; deadline = cyc + TO; end
                   else if (cyc == deadline) begin to_evt = 1; m_phase = enable ? 1 : 0; end
                3: if (!cap_busy) begin
                       frame_evt = 1;
                       burst_count = (burst_count + 1) % (CNT_MAX + 1);
                       if (burst_frames != 0 && burst_count == int'(burst_frames)) begin
                           m_phase = 4; e_bdone = 1;
                       end else m_phase = enable ? 1 : 0;
                   end else if (cyc == deadline) begin to_evt = 1; m_phase = 0; end
                4: if (!enable) m_phase = 0;
                default: m_phase = 0;
            endcase
            if (stat_clear) begin
                e_frames = 0; e_missed = 0; e_sticky = 0;
            end else begin
                if (frame_evt) e_frames = (e_frames + 1) % (CNT_MAX + 1);
                if (miss_evt && e_missed < CNT_MAX) e_missed++;
                if (to_evt) e_sticky = 1;
            end
        end
    end

    // Ingest busy model: rises bm_delay cycles after a start is seen, lasts bm_len cycles.
    int bm_delay = 0, bm_len = 50, busy_wait = -1, busy_left = 0;
    bit bm_never = 0;
    int starts_seen = 0, bursts_seen = 0;

    task automatic next_cycle();
        @(negedge clk);
        check_value("cap_start", cap_start, e_start);
        check_value("seq_active", seq_active, (m_phase != 0));
        check_value("burst_done", burst_done, e_bdone);
        check_value("frames_done", frames_done, e_frames);
        check_value("missed_triggers", missed_triggers, e_missed);
        check_value("timeout_sticky", timeout_sticky, e_sticky);
        if (cap_start) begin
            starts_seen++;
            $display("start t=%0t frames=%0d missed=%0d sticky=%0d", $time, frames_done,
                     missed_triggers, timeout_sticky);
        end
        if (burst_done) bursts_seen++;
        if (cap_busy) begin
            if (busy_left <= 1) cap_busy = 1'b0;
            else busy_left--;
        end
        if (cap_start && !bm_never) busy_wait = bm_delay;
        if (busy_wait == 0) begin
            cap_busy = 1'b1; busy_left = bm_len; busy_wait = -1;
        end else if (busy_wait > 0) busy_wait--;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (cap_start !== 1'b1 && n < limit);
        check_value("start_seen", cap_start, 1);
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        next_cycle();
        stat_clear = 1'b0;
    endtask

    int lat, n, m0, f0;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_value("reset_cap_start", cap_start, 0);
        check_value("reset_seq_active", seq_active, 0);
        check_value("reset_frames", frames_done, 0);
        rst_n = 1'b1;
        next_cycle();

        // DRDY-triggered burst of three, then a fall while the burst is held
        mode_periodic = 0; burst_frames = 3; bm_delay = 0; bm_len = 50; enable = 1;
        repeat (5) next_cycle();
        bursts_seen = 0;
        for (int f = 0; f < 3; f++) begin
            adc_drdy_n = 0;
            wait_start(20, lat);
            check_value("drdy_latency", lat, SYNC_STAGES + 2);
            repeat (20) next_cycle();
            adc_drdy_n = 1;
            repeat (200 - 20 - lat) next_cycle();
        end
        check_value("t1_frames", frames_done, 3);
        check_value("t1_bursts", bursts_seen, 1);
        check_value("t1_held", seq_active, 1);
        starts_seen = 0;
        adc_drdy_n = 0; repeat (10) next_cycle();
        adc_drdy_n = 1; repeat (5) next_cycle();
        check_value("t1_missed", missed_triggers, 1);
        check_value("t1_no_start", starts_seen, 0);

        // Periodic triggers, short then overlong busy
        enable = 0; next_cycle(); pulse_clear();
        mode_periodic = 1; period_cycles = 100; burst_frames = 0; bm_len = 30;
        enable = 1; starts_seen = 0;
        repeat (1010) next_cycle();
        check_value("t2_starts", starts_seen, 10);
        check_value("t2_frames", frames_done, 9);
        check_value("t2_missed", missed_triggers, 0);
        bm_len = 150; m0 = missed_triggers;
        repeat (1000) next_cycle();
        check_value("t2_missed_grows", (missed_triggers >= m0 + 3), 1);

        // Busy never answers: LAUNCH watchdog
        enable = 0; mode_periodic = 0; repeat (300) next_cycle();
        pulse_clear();
        bm_never = 1; enable = 1; repeat (5) next_cycle();
        adc_drdy_n = 0;
        wait_start(20, lat);
        n = 0;
        do begin next_cycle(); n++; end while (!timeout_sticky && n < TO + 10);
        check_value("t3_timeout_latency", n, TO);
        check_value("t3_frames", frames_done, 0);
        check_value("t3_armed", seq_active, 1);
        adc_drdy_n = 1;
        pulse_clear();
        check_value("t3_cleared", timeout_sticky, 0);
        bm_never = 0;

        // Minimum period and saturation of the missed counter
        for (int p = 0; p < 2; p++) begin
            enable = 0; repeat (5) next_cycle(); pulse_clear();
            mode_periodic = 1; period_cycles = p; burst_frames = 1; bm_len = 3; enable = 1;
            repeat (40) next_cycle();
            m0 = missed_triggers;
            repeat (20) next_cycle();
            check_value("t4_tick_every_2", missed_triggers - m0, 10);
        end
        repeat (600) next_cycle();
        check_value("t4_saturated", missed_triggers, CNT_MAX);

        // Enable dropped mid-capture: frame finishes, then no more starts
        enable = 0; repeat (5) next_cycle(); pulse_clear();
        mode_periodic = 0; burst_frames = 0; bm_len = 50; enable = 1;
        repeat (5) next_cycle();
        adc_drdy_n = 0;
        wait_start(20, lat);
        repeat (10) next_cycle();
        enable = 0; f0 = frames_done;
        repeat (60) next_cycle();
        check_value("t5_frame_done", frames_done, f0 + 1);
        check_value("t5_idle", seq_active, 0);
        starts_seen = 0;
        for (int k = 0; k < 3; k++) begin
            adc_drdy_n = 1; repeat (10) next_cycle();
            adc_drdy_n = 0; repeat (10) next_cycle();
        end
        check_value("t5_no_start", starts_seen, 0);

        // Asynchronous reset while waiting in LAUNCH with the pin low
        adc_drdy_n = 1; bm_never = 1; enable = 1; repeat (5) next_cycle();
        adc_drdy_n = 0;
        wait_start(20, lat);
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_value("async_cap_start", cap_start, 0);
        check_value("async_seq_active", seq_active, 0);
        check_value("async_burst_done", burst_done, 0);
        check_value("async_frames", frames_done, 0);
        check_value("async_missed", missed_triggers, 0);
        check_value("async_sticky", timeout_sticky, 0);
        model_reset();
        busy_wait = -1; cap_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        starts_seen = 0;
        repeat (20) next_cycle();
        check_value("t6_no_spurious", starts_seen, 0);
        adc_drdy_n = 1; repeat (3) next_cycle();
        adc_drdy_n = 0;
        wait_start(20, lat);
        check_value("t6_fresh_edge", lat, SYNC_STAGES + 2);
        bm_never = 0;

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 399) == 0) mode_periodic = ~mode_periodic;
            if ($urandom_range(0, 199) == 0) period_cycles = PERIOD_W'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) burst_frames = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) adc_drdy_n = ~adc_drdy_n;
            if ($urandom_range(0, 99) == 0) begin
                bm_delay = $urandom_range(0, 3);
                bm_len = ($urandom_range(0, 9) == 0) ? 250 : $urandom_range(1, 30);
            end
            stat_clear = ($urandom_range(0, 299) == 0);
            next_cycle();
        end
        stat_clear = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
